// File: rtl/flash_conv_ctrl_if.sv
// Port bundle between the flash ADC conversion sequencer and its surroundings:
// comparator-side controls, the start request and the valid/ready result port.
interface flash_conv_ctrl_if;
    logic        start;
    logic [14:0] Y;
    logic        az;
    logic        latch;
    logic        busy;
    logic [3:0]  dout;
    logic        dout_err;
    logic        dout_valid;
    logic        dout_ready;

    modport master (
        output start, Y, dout_ready,
        input  az, latch, busy, dout, dout_err, dout_valid
    );

    modport slave (
        input  start, Y, dout_ready,
        output az, latch, busy, dout, dout_err, dout_valid
    );
endinterface

// File: rtl/flash_conv_ctrl.sv
// Conversion sequencer for the 4-bit flash ADC: auto-zero, settle, latch, capture,
// bubble-correct, encode and optionally average before handing off the result.

module flash_conv_cell (
    input  logic hi,
    input  logic mid,
    input  logic lo,
    output logic c,
    output logic bub
);
    assign c   = (hi & mid) | (hi & lo) | (mid & lo);
    // A one directly below a zero breaks the thermometer shape.
    assign bub = mid & ~hi;
endmodule

module flash_conv_ctrl #(
    parameter int AZ_CYC     = 4,
    parameter int SETTLE_CYC = 2,
    parameter int AVG_LOG2   = 0
) (
    input  logic              clk,
    input  logic              rst,
    flash_conv_ctrl_if.slave  bus
);
    localparam int NBITS = 15;
    localparam int AW    = 4 + AVG_LOG2;
    localparam int CW    = 8;
    localparam int SW    = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AZERO,
        S_SETTLE,
        S_LATCH,
        S_CAPT,
        S_ACC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [SW-1:0]    smp_q, smp_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [NBITS-1:0] y_q, y_d;
    logic [3:0]       dout_q, dout_d;
    logic             err_q, err_d;
    logic             az_q, az_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;
    logic             vld_q, vld_d;

    // Virtual Y[15]=1 above and Y[-1]=0 below the captured word.
    logic [NBITS+1:0] y_ext;
    logic [NBITS-1:0] corr;
    logic [NBITS-1:0] bub;
    logic [3:0]       code;
    logic             samp_err;
    logic [AW-1:0]    acc_sum;

    assign y_ext = {1'b1, y_q, 1'b0};

    generate
        for (genvar i = 0; i < NBITS; i++) begin : g_cell
            flash_conv_cell u_cell (
                .hi  (y_ext[i+2]),
                .mid (y_ext[i+1]),
                .lo  (y_ext[i]),
                .c   (corr[i]),
                .bub (bub[i])
            );
        end
    endgenerate

    always_comb begin
        code = '0;
        for (int i = 0; i < NBITS; i++) begin
            code = code + 4'(corr[i]);
        end
    end

    assign samp_err = |bub;
    assign acc_sum  = acc_q + AW'(code);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        smp_d   = smp_q;
        acc_d   = acc_q;
        y_d     = y_q;
        dout_d  = dout_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_AZERO;
                    cyc_d   = '0;
                    smp_d   = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_AZERO: begin
                if (cyc_q == CW'(AZ_CYC - 1)) begin
                    state_d = S_SETTLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cyc_q == CW'(SETTLE_CYC - 1)) begin
                    state_d = S_LATCH;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_LATCH: state_d = S_CAPT;
            // Comparator outputs are valid the cycle after the strobe.
            S_CAPT: begin
                y_d     = bus.Y;
                state_d = S_ACC;
            end
            S_ACC: begin
                acc_d = acc_sum;
                err_d = err_q | samp_err;
                if (smp_q < SW'((1 << AVG_LOG2) - 1)) begin
                    smp_d   = smp_q + 1'b1;
                    cyc_d   = '0;
                    state_d = S_AZERO;
                end else begin
                    dout_d  = acc_sum[AVG_LOG2 +: 4];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (vld_q && bus.dout_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered images of the state being entered.
    always_comb begin
        az_d    = (state_d == S_AZERO);
        latch_d = (state_d == S_LATCH);
        busy_d  = (state_d != S_IDLE);
        vld_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            smp_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            az_q    <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            smp_q   <= smp_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            az_q    <= az_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.az         = az_q;
    assign bus.latch      = latch_q;
    assign bus.busy       = busy_q;
    assign bus.dout       = dout_q;
    assign bus.dout_err   = err_q;
    assign bus.dout_valid = vld_q;
endmodule

// File: tb/tb_flash_conv_ctrl.sv
// Directed bench for flash_conv_ctrl: default instance plus a 4-sample averaging instance.
module tb_flash_conv_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    flash_conv_ctrl_if bus0 ();
    flash_conv_ctrl_if bus2 ();

    flash_conv_ctrl u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    flash_conv_ctrl #(.AZ_CYC(4), .SETTLE_CYC(2), .AVG_LOG2(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one conversion on the default instance with dout_ready=1.
    task automatic run_conv0(input logic [14:0] y, output logic [3:0] d,
                             output logic e, output bit to);
        to = 1'b1;
        d  = 'x;
        e  = 'x;
        @(negedge clk);
        bus0.Y     = y;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus0.dout_valid) begin
                d  = bus0.dout;
                e  = bus0.dout_err;
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst             = 1'b0;
        bus0.start      = 1'b0;
        bus0.Y          = '0;
        bus0.dout_ready = 1'b1;
        bus2.start      = 1'b0;
        bus2.Y          = '0;
        bus2.dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus0.az, bus0.latch, bus0.busy, bus0.dout, bus0.dout_err, bus0.dout_valid} !== 9'b0) begin
            errors++;
            $display("FAIL reset0 got az=%b latch=%b busy=%b dout=%0d err=%b vld=%b want all 0",
                     bus0.az, bus0.latch, bus0.busy, bus0.dout, bus0.dout_err, bus0.dout_valid);
        end
        checks++;
        if ({bus2.az, bus2.latch, bus2.busy, bus2.dout, bus2.dout_err, bus2.dout_valid} !== 9'b0) begin
            errors++;
            $display("FAIL reset2 got az=%b latch=%b busy=%b dout=%0d vld=%b want all 0",
                     bus2.az, bus2.latch, bus2.busy, bus2.dout, bus2.dout_valid);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic ea, el, ev, eb;
        bus0.Y          = 15'b111111111111000;
        bus0.dout_ready = 1'b1;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) bus0.start = 1'b0;
            ea = (n <= 4);
            el = (n == 7);
            ev = (n == 10);
            eb = (n <= 10);
            checks++;
            if ({bus0.az, bus0.latch, bus0.dout_valid, bus0.busy} !== {ea, el, ev, eb}) begin
                errors++;
                $display("FAIL latency_t%0d got az/latch/vld/busy=%b%b%b%b want %b%b%b%b", n,
                         bus0.az, bus0.latch, bus0.dout_valid, bus0.busy, ea, el, ev, eb);
            end
            if (n == 10) begin
                checks++;
                if (bus0.dout !== 4'd12 || bus0.dout_err !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_result got dout=%0d err=%b want 12 0",
                             bus0.dout, bus0.dout_err);
                end
            end
        end
    endtask

    task automatic test_sweep();
        logic [14:0] y;
        logic [3:0]  d;
        logic        e;
        bit          to;
        for (int k = 0; k < 16; k++) begin
            y = 15'h7fff;
            y = y << k;
            run_conv0(y, d, e, to);
            checks++;
            if (to || d !== 4'(15 - k) || e !== 1'b0) begin
                errors++;
                $display("FAIL sweep_k%0d got dout=%0d err=%b timeout=%0d want %0d 0 0",
                         k, d, e, to, 15 - k);
            end
        end
    endtask

    task automatic test_bubble();
        logic [3:0] d;
        logic       e;
        bit         to;
        run_conv0(15'b111111101111000, d, e, to);
        checks++;
        if (to || d !== 4'd12 || e !== 1'b1) begin
            errors++;
            $display("FAIL bubble7 got dout=%0d err=%b timeout=%0d want 12 1", d, e, to);
        end
        run_conv0(15'b100000000000000, d, e, to);
        checks++;
        if (to || d !== 4'd1 || e !== 1'b0) begin
            errors++;
            $display("FAIL top_only got dout=%0d err=%b timeout=%0d want 1 0", d, e, to);
        end
        // Error flag must clear at the next start.
        run_conv0(15'b111110000000000, d, e, to);
        checks++;
        if (to || d !== 4'd5 || e !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got dout=%0d err=%b timeout=%0d want 5 0", d, e, to);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        seen = 1'b0;
        bus0.dout_ready = 1'b0;
        bus0.Y          = 15'b111110000000000;
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus0.dout_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_wait got no dout_valid want dout_valid within 40 cycles");
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            bus0.start = (n == 1);
            checks++;
            if (bus0.dout !== 4'd5 || bus0.dout_valid !== 1'b1 || bus0.busy !== 1'b1 ||
                bus0.az !== 1'b0 || bus0.latch !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got dout=%0d vld=%b busy=%b az=%b latch=%b want 5 1 1 0 0",
                         n, bus0.dout, bus0.dout_valid, bus0.busy, bus0.az, bus0.latch);
            end
        end
        bus0.start      = 1'b0;
        bus0.dout_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus0.dout_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.dout !== 4'd5) begin
            errors++;
            $display("FAIL bp_accept got vld=%b busy=%b dout=%0d want 0 0 5",
                     bus0.dout_valid, bus0.busy, bus0.dout);
        end
        @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b0 || bus0.az !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle got busy=%b az=%b want 0 0", bus0.busy, bus0.az);
        end
    endtask

    task automatic test_avg();
        int         latches;
        int         overlap;
        bit         seen;
        logic [3:0] d;
        logic       e;
        latches = 0;
        overlap = 0;
        seen    = 1'b0;
        d       = 'x;
        e       = 'x;
        bus2.dout_ready = 1'b1;
        bus2.Y          = 15'h7fff;
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus2.az && bus2.latch) overlap++;
            if (bus2.latch) begin
                bus2.Y = (latches < 2) ? 15'h7fff : 15'h0000;
                latches++;
            end
            if (bus2.dout_valid) begin
                d    = bus2.dout;
                e    = bus2.dout_err;
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen || latches != 4) begin
            errors++;
            $display("FAIL avg_latches got %0d pulses valid_seen=%0d want 4 1", latches, seen);
        end
        checks++;
        if (d !== 4'd7 || e !== 1'b0) begin
            errors++;
            $display("FAIL avg_result got dout=%0d err=%b want 7 0", d, e);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL avg_overlap got %0d az&latch cycles want 0", overlap);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0] d;
        logic       e;
        bit         to;
        bus0.Y = 15'b111111111111000;
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.az !== 1'b1 || bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre got az=%b busy=%b want 1 1", bus0.az, bus0.busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus0.az !== 1'b0 || bus0.busy !== 1'b0 || bus0.dout_valid !== 1'b0 || bus0.dout !== 4'd0) begin
            errors++;
            $display("FAIL rmid_async got az=%b busy=%b vld=%b dout=%0d want 0 0 0 0",
                     bus0.az, bus0.busy, bus0.dout_valid, bus0.dout);
        end
        @(negedge clk);
        rst = 1'b1;
        run_conv0(15'b111111111111000, d, e, to);
        checks++;
        if (to || d !== 4'd12 || e !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after got dout=%0d err=%b timeout=%0d want 12 0", d, e, to);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
        test_sweep();
        test_bubble();
        test_backpressure();
        test_avg();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
